// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: turns the sequencer's 3-bit colour code into three PWM LED
// channels. Each channel's duty cycle walks towards its target by at most
// STEP per PWM period, so colour changes fade instead of snapping.

// One LED channel: duty ramp toward target plus the PWM comparator.
module rgb_pwm_chan #(
    parameter int PWM_W = 8,
    parameter int LEVEL = 192,
    parameter int STEP  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             on,
    input  logic             boundary,
    input  logic [PWM_W-1:0] pwm_cnt,
    output logic             led,
    output logic [PWM_W-1:0] duty,
    output logic             busy
);
    // One spare bit so the step arithmetic can never wrap.
    localparam logic [PWM_W:0] LVL = (PWM_W+1)'(LEVEL);
    localparam logic [PWM_W:0] STP = (PWM_W+1)'(STEP);

    logic [PWM_W:0]   cur, tgt, gap_up, gap_dn;
    logic [PWM_W-1:0] nxt;

    assign cur    = {1'b0, duty};
    assign tgt    = on ? LVL : '0;
    assign gap_up = tgt - cur;
    assign gap_dn = cur - tgt;
    assign busy   = (cur != tgt);

    // Next duty: one STEP toward the target, landing exactly on it when closer.
    always_comb begin
        nxt = duty;
        if (cur < tgt)
            nxt = (gap_up <= STP) ? PWM_W'(tgt) : PWM_W'(cur + STP);
        else if (cur > tgt)
            nxt = (gap_dn <= STP) ? PWM_W'(tgt) : PWM_W'(cur - STP);
    end

    // Duty only moves on the last cycle of a period; led is the registered compare.
    always_ff @(posedge clk) begin
        if (!rst) begin
            duty <= '0;
            led  <= 1'b0;
        end else begin
            if (boundary)
                duty <= nxt;
            led <= (pwm_cnt < duty);
        end
    end
endmodule

module rgb_pwm_driver #(
    parameter int PWM_W = 8,
    parameter int LEVEL = 192,
    parameter int STEP  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       colour,
    output logic             led_r,
    output logic             led_g,
    output logic             led_b,
    output logic [PWM_W-1:0] duty_r,
    output logic [PWM_W-1:0] duty_g,
    output logic [PWM_W-1:0] duty_b,
    output logic             busy,
    output logic             period_start
);
    localparam int NUM_CH = 3;

    logic [PWM_W-1:0]             pwm_cnt;
    logic                         boundary;
    logic [NUM_CH-1:0]            led;
    logic [NUM_CH-1:0]            ch_busy;
    logic [NUM_CH-1:0][PWM_W-1:0] duty;

    assign boundary = (pwm_cnt == {PWM_W{1'b1}});

    // Free-running period counter and start-of-period strobe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pwm_cnt      <= '0;
            period_start <= 1'b0;
        end else begin
            pwm_cnt      <= pwm_cnt + 1'b1;
            period_start <= boundary;
        end
    end

    // Channel i follows colour[i]: 2 = red, 1 = green, 0 = blue.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        rgb_pwm_chan #(
            .PWM_W (PWM_W),
            .LEVEL (LEVEL),
            .STEP  (STEP)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .on       (colour[i]),
            .boundary (boundary),
            .pwm_cnt  (pwm_cnt),
            .led      (led[i]),
            .duty     (duty[i]),
            .busy     (ch_busy[i])
        );
    end

    assign led_r  = led[2];
    assign led_g  = led[1];
    assign led_b  = led[0];
    assign duty_r = duty[2];
    assign duty_g = duty[1];
    assign duty_b = duty[0];
    assign busy   = |ch_busy;
endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: two instances (LEVEL 192 and LEVEL 200) checked
// every cycle against a period-level reference model, plus directed checks of
// reset, ramp, crossfade, mid-period colour changes, clamping and reset mid-ramp.
module tb_rgb_pwm_driver;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]            rstn;
    logic [1:0][2:0]       col;
    logic [1:0][2:0]       led;
    logic [1:0][2:0][7:0]  dty;
    logic [1:0]            bsy;
    logic [1:0]            ps;

    rgb_pwm_driver #(.PWM_W(8), .LEVEL(192), .STEP(16)) dut0 (
        .clk(clk), .rst(rstn[0]), .colour(col[0]),
        .led_r(led[0][2]), .led_g(led[0][1]), .led_b(led[0][0]),
        .duty_r(dty[0][2]), .duty_g(dty[0][1]), .duty_b(dty[0][0]),
        .busy(bsy[0]), .period_start(ps[0])
    );

    rgb_pwm_driver #(.PWM_W(8), .LEVEL(200), .STEP(16)) dut1 (
        .clk(clk), .rst(rstn[1]), .colour(col[1]),
        .led_r(led[1][2]), .led_g(led[1][1]), .led_b(led[1][0]),
        .duty_r(dty[1][2]), .duty_g(dty[1][1]), .duty_b(dty[1][0]),
        .busy(bsy[1]), .period_start(ps[1])
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int lvl[2] = '{192, 200};
    int mcnt[2];
    int md[2][3];
    bit mled[2][3];
    bit mps[2];

    function automatic int approach(input int d, input int t, input int s);
        if (d < t) return (d + s > t) ? t : d + s;
        if (d > t) return (d - s < t) ? t : d - s;
        return d;
    endfunction

    function automatic int tgt_of(input int u, input int ch);
        return col[u][ch] ? lvl[u] : 0;
    endfunction

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (!rstn[u]) begin
                mcnt[u] <= 0;
                mps[u]  <= 1'b0;
                for (int ch = 0; ch < 3; ch++) begin
                    md[u][ch]   <= 0;
                    mled[u][ch] <= 1'b0;
                end
            end else begin
                mcnt[u] <= (mcnt[u] + 1) % 256;
                mps[u]  <= (mcnt[u] == 255);
                for (int ch = 0; ch < 3; ch++) begin
                    mled[u][ch] <= (mcnt[u] < md[u][ch]);
                    if (mcnt[u] == 255)
                        md[u][ch] <= approach(md[u][ch], tgt_of(u, ch), 16);
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the clock edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int u = 0; u < 2; u++) begin
                int eb;
                eb = 0;
                for (int ch = 0; ch < 3; ch++)
                    if (md[u][ch] != tgt_of(u, ch)) eb = 1;
                check("period_start", int'(ps[u]), int'(mps[u]));
                check("busy", int'(bsy[u]), eb);
                for (int ch = 0; ch < 3; ch++) begin
                    check("duty", int'(dty[u][ch]), md[u][ch]);
                    check("led", int'(led[u][ch]), int'(mled[u][ch]));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ps(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!ps[0] && n < 400);
        check("ps_seen", int'(ps[0]), 1);
    endtask

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    initial begin
        int n, hi_r, hi_g;
        rstn = 2'b00;
        col  = '0;

        // Reset
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        check("rst_duty_r", int'(dty[0][2]), 0);
        check("rst_led_r", int'(led[0][2]), 0);
        check("rst_busy", int'(bsy[0]), 0);
        check("rst_ps", int'(ps[0]), 0);

        // Ramp up on red for both instances
        rstn = 2'b11;
        col[0] = 3'b100;
        col[1] = 3'b100;
        #1;
        check("busy_immediate", int'(bsy[0]), 1);
        wait_ps(n);
        check("first_ps_latency", n, 256);
        check("ramp0_b1", int'(dty[0][2]), 16);
        check("ramp1_b1", int'(dty[1][2]), 16);
        for (int b = 2; b <= 13; b++) begin
            wait_ps(n);
            check("ramp_period", n, 256);
            check("ramp0", int'(dty[0][2]), min2(16 * b, 192));
            check("ramp1", int'(dty[1][2]), min2(16 * b, 200));
            if (b == 12) check("ramp0_done_busy", int'(bsy[0]), 0);
        end
        check("clamp_up_200", int'(dty[1][2]), 200);
        check("ramp1_done_busy", int'(bsy[1]), 0);

        // Steady state duty ratio
        hi_r = 0;
        hi_g = 0;
        for (int c = 0; c < 256; c++) begin
            tick();
            hi_r += int'(led[0][2]);
            hi_g += int'(led[0][1]) + int'(led[0][0]);
        end
        check("steady_r_high", hi_r, 192);
        check("steady_gb_high", hi_g, 0);

        // Crossfade on dut0, clamp-down on dut1
        col[0] = 3'b011;
        col[1] = 3'b000;
        for (int b = 1; b <= 13; b++) begin
            wait_ps(n);
            check("xfade_r", int'(dty[0][2]), max2(192 - 16 * b, 0));
            check("xfade_g", int'(dty[0][1]), min2(16 * b, 192));
            check("xfade_b", int'(dty[0][0]), min2(16 * b, 192));
            check("down1_r", int'(dty[1][2]), max2(200 - 16 * b, 0));
        end
        check("xfade_busy", int'(bsy[0]), 0);
        check("clamp_down_0", int'(dty[1][2]), 0);

        // Colour pulse during cnt 100..200 only: no duty change
        n = 0;
        while (mcnt[0] != 100 && n < 300) begin tick(); n++; end
        col[0] = 3'b100;
        repeat (101) tick();
        col[0] = 3'b011;
        wait_ps(n);
        check("pulse_r", int'(dty[0][2]), 0);
        check("pulse_g", int'(dty[0][1]), 192);

        // Persistent mid-period change takes effect at the next boundary only
        n = 0;
        while (mcnt[0] != 100 && n < 300) begin tick(); n++; end
        col[0] = 3'b100;
        tick();
        check("mid_hold_r", int'(dty[0][2]), 0);
        wait_ps(n);
        check("mid_r", int'(dty[0][2]), 16);
        check("mid_g", int'(dty[0][1]), 176);

        // Reset in the middle of a ramp
        for (int b = 0; b < 5; b++) wait_ps(n);
        check("pre_rst_r", int'(dty[0][2]), 96);
        repeat (37) tick();
        rstn[0] = 1'b0;
        tick();
        check("midrst_duty", int'(dty[0][2]), 0);
        check("midrst_led", int'(led[0][2]), 0);
        rstn[0] = 1'b1;
        wait_ps(n);
        check("restart_latency", n, 256);
        check("restart_r", int'(dty[0][2]), 16);

        // Randomized colours and occasional resets, model-checked each cycle
        for (int it = 0; it < 24; it++) begin
            for (int u = 0; u < 2; u++) begin
                col[u] = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 5) == 0) rstn[u] = 1'b0;
            end
            repeat ($urandom_range(1, 3)) tick();
            rstn = 2'b11;
            repeat ($urandom_range(1, 700)) tick();
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
